// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external 4-bit ALU between two requesters.
// Optional per-requester completed-op counters: define ALU_SHARE_OPCOUNT_EN.
module alu_share_arbiter #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [1:0]       op0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       op1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] res_data,
    output logic             res_valid0,
    output logic             res_valid1,
    output logic             busy,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [1:0]       alu_S,
    input  logic [WIDTH-1:0] alu_result
`ifdef ALU_SHARE_OPCOUNT_EN
    ,
    output logic [7:0]       op_count0,
    output logic [7:0]       op_count1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             ack0_q, ack0_d, ack1_q, ack1_d;
    logic             rv0_q, rv0_d, rv1_q, rv1_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] res_q, res_d, a_q, a_d, b_q, b_d;
    logic [1:0]       s_q, s_d;
    logic             gnt0, gnt1;

    // On a tie the requester that did not win last time is served.
    assign gnt1 = req1 && (!req0 || !last_q);
    assign gnt0 = req0 && !gnt1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
        busy_d  = busy_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (gnt0 || gnt1) begin
                    state_d = EXEC;
                    busy_d  = 1'b1;
                    owner_d = gnt1;
                    last_d  = gnt1;
                    ack0_d  = gnt0;
                    ack1_d  = gnt1;
                    cnt_d   = HOLD_LOAD;
                    a_d     = gnt1 ? a1 : a0;
                    b_d     = gnt1 ? b1 : b0;
                    s_d     = gnt1 ? op1 : op0;
                end
            end
            EXEC: begin
                busy_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    res_d   = alu_result;
                    state_d = RESP;
                    rv0_d   = !owner_q;
                    rv1_d   = owner_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            busy_q  <= 1'b0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            busy_q  <= busy_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign res_valid0 = rv0_q;
    assign res_valid1 = rv1_q;
    assign busy       = busy_q;
    assign res_data   = res_q;
    assign alu_A      = a_q;
    assign alu_B      = b_q;
    assign alu_S      = s_q;

`ifdef ALU_SHARE_OPCOUNT_EN
    logic [7:0] opc0_q, opc1_q;

    // Counts advance on the same edge that raises the matching res_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            opc0_q <= 8'd0;
            opc1_q <= 8'd0;
        end else begin
            if (rv0_d) opc0_q <= opc0_q + 8'd1;
            if (rv1_d) opc1_q <= opc1_q + 8'd1;
        end
    end

    assign op_count0 = opc0_q;
    assign op_count1 = opc1_q;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 4-bit ALU between two requesters.
- ALU contract: S=00 XOR, 01 AND, 10 OR, 11 ADD mod 16, no carry out.
- Block arbitrates round-robin, latches the winner's operands and op code, drives the ALU and holds its inputs stable for a programmable settle time.
- Captures the ALU result and returns it to the winning requester with a one-cycle valid pulse.
- Sits between lab-level requesters (switch/FSM front ends) and the ALU instance.

Parameters:
WIDTH, 4, operand/result width; must match the ALU.
HOLD_CYCLES, 1, cycles ALU inputs are held stable before capture; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req0  input  1  requester 0 request; held high until ack0 seen.
a0  input  WIDTH  requester 0 operand A.
b0  input  WIDTH  requester 0 operand B.
op0  input  2  requester 0 ALU select.
req1, a1, b1, op1  input  1/WIDTH/WIDTH/2  requester 1, same meaning.
ack0  output  1  one-cycle pulse: requester 0 request accepted.
ack1  output  1  one-cycle pulse: requester 1 request accepted.
res_data  output  WIDTH  result of the last completed operation.
res_valid0  output  1  one-cycle pulse: res_data belongs to requester 0.
res_valid1  output  1  one-cycle pulse: res_data belongs to requester 1.
busy  output  1  high while an operation is in flight (EXEC or RESP).
alu_A  output  WIDTH  to ALU operand A.
alu_B  output  WIDTH  to ALU operand B.
alu_S  output  2  to ALU select.
alu_result  input  WIDTH  from ALU output.

Behaviour:
- Reset (synchronous, active-high; dominates all other inputs):
  - Outputs: state=IDLE; ack0/1, res_valid0/1, busy = 0; res_data, alu_A, alu_B, alu_S = 0.
  - Internal: last_grant=1, so requester 0 wins the first tie; hold counter = 0.
- FSM states: IDLE, EXEC, RESP. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: grant it.
  - Both high: grant the requester other than last_grant.
  - On the grant edge: load the winner's a/b/op into alu_A/alu_B/alu_S; set owner; update last_grant; load hold counter with HOLD_CYCLES-1; go to EXEC.
  - ack of the winner is high for exactly the first EXEC cycle.
- EXEC:
  - alu_A/B/S constant; busy=1.
  - Counter decrements each cycle; at 0, capture alu_result into res_data and go to RESP.
  - EXEC lasts exactly HOLD_CYCLES cycles.
- RESP: res_valid of the owner = 1 for one cycle, busy=1; then go to IDLE.
- Latency: grant edge to res_valid = HOLD_CYCLES+1 cycles. Throughput: one op per HOLD_CYCLES+2 cycles.
- Requests arriving while busy are ignored until IDLE; requesters keep req high. No queueing beyond that.
- A req still high in IDLE after its res_valid is treated as a new request.
- Requests with both req high continuously alternate 0,1,0,1.
- res_data and alu_A/B/S retain their last values in IDLE.
- Reset mid-operation: abort; no ack or res_valid is generated for the aborted op.
- Operand inputs are sampled only on the grant edge; later changes do not affect the in-flight op.

Optional Feature:
- Macro: ALU_SHARE_OPCOUNT_EN.
- Defined:
  - Adds output ports op_count0 and op_count1 (8 bits each).
  - Each increments on its requester's res_valid pulse, wrapping 255 to 0.
  - Both clear on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request, HOLD_CYCLES=1: req0, a0=1001, b0=1001, op0=11 → ack0 one cycle after the grant edge; res_valid0 two cycles after the grant edge; res_data=0010; res_valid1 never high.
- Tie after reset: req0 with 0000/1111/op 00, and req1 with 1111/1111/op 01, both held high → requester 0 served first (res_data=1111, res_valid0), then requester 1 (res_data=1111, res_valid1).
- Fairness: both req held high for 6 ops → grant order 0,1,0,1,0,1; each op spans exactly HOLD_CYCLES+2 cycles.
- Late arrival: req1 (1010/0101/op 11) raised while busy on req0 (0010/0011/op 10) → req0 result 0011 first; req1 granted on the next IDLE edge with result 1111.
- Reset mid-op, HOLD_CYCLES=4: reset asserted in the 2nd EXEC cycle → next cycle all outputs 0 and busy=0; no res_valid; the next tie goes to requester 0.
- With ALU_SHARE_OPCOUNT_EN defined: 3 ops for requester 0 and 2 for requester 1 → op_count0=3, op_count1=2; reset → both 0.
